// File: rtl/sparc_mem_pkg.sv
// Shared encodings and helpers for the SPARC big-endian memory responder.
package sparc_mem_pkg;

  // Access-size encodings carried on the Type bus.
  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;
  localparam logic [1:0] TYPE_RSVD = 2'b11;

  // Direction encodings carried on RW.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Responder handshake states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the access is naturally aligned and uses a defined size.
  function automatic logic align_ok(input logic [1:0] typ, input logic [1:0] addr_lo);
    case (typ)
      TYPE_BYTE: return 1'b1;
      TYPE_HALF: return ~addr_lo[0];
      TYPE_WORD: return (addr_lo == 2'b00);
      TYPE_RSVD: return 1'b0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sparc_mem_lane.sv
// Big-endian byte lane steering: maps right-justified bus data onto the
// bytes at A, A+1, A+2, A+3 (index 0 = lowest address = most significant).
module sparc_mem_lane
  import sparc_mem_pkg::*;
(
  input  logic [1:0]      type_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0][7:0] rbytes_i,
  output logic [3:0][7:0] wbytes_o,
  output logic [3:0]      wen_o,
  output logic [31:0]     rdata_o
);

  // Pack write bytes / unpack read bytes for the requested access size.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis would infer a latch.
    wbytes_o = '0;
    wen_o    = 4'b0000;
    rdata_o  = '0;
    case (type_i)
      TYPE_BYTE: begin
        wbytes_o[0] = wdata_i[7:0];
        wen_o       = 4'b0001;
        rdata_o     = {24'h0, rbytes_i[0]};
      end
      TYPE_HALF: begin
        wbytes_o[0] = wdata_i[15:8];
        wbytes_o[1] = wdata_i[7:0];
        wen_o       = 4'b0011;
        rdata_o     = {16'h0, rbytes_i[0], rbytes_i[1]};
      end
      TYPE_WORD: begin
        wbytes_o[0] = wdata_i[31:24];
        wbytes_o[1] = wdata_i[23:16];
        wbytes_o[2] = wdata_i[15:8];
        wbytes_o[3] = wdata_i[7:0];
        wen_o       = 4'b1111;
        rdata_o     = {rbytes_i[0], rbytes_i[1], rbytes_i[2], rbytes_i[3]};
      end
      TYPE_RSVD: begin
        wen_o = 4'b0000;
      end
      default: begin
        wen_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/sparc_mem_responder.sv
// Byte-addressable RAM answering the MOV/RW/Type request strobe with a
// four-phase MOC handshake, configurable wait states and alignment checking.
module sparc_mem_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Type,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Align_Err
);

  localparam int DEPTH = 2 ** ADDR_W;

  // BUSY lasts WAIT_STATES+1 cycles, so MOC is first seen WAIT_STATES+1
  // edges after the request is accepted.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              commit;

  logic              rw_q;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       dout_q;

  logic [7:0]        mem [DEPTH];

  logic [3:0][7:0]   rbytes;
  logic [3:0][7:0]   wbytes;
  logic [3:0]        wen;
  logic [31:0]       rdata;
  logic              ok;

  assign ok = align_ok(type_q, addr_q[1:0]);

  // Gather the four bytes starting at the latched address; offsets wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rbytes[i] = mem[addr_q + ADDR_W'(i)];
    end
  end

  sparc_mem_lane u_lane (
    .type_i   (type_q),
    .wdata_i  (data_q),
    .rbytes_i (rbytes),
    .wbytes_o (wbytes),
    .wen_o    (wen),
    .rdata_o  (rdata)
  );

  // Next-state logic: accept in IDLE, count down in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MOV) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          commit  = ~Reset;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!MOV) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, wait counter, request latches and read-data register.
  always_ff @(posedge Clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_READ;
      type_q  <= TYPE_BYTE;
      addr_q  <= '0;
      data_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q   <= RW;
        type_q <= Type;
        addr_q <= Address[ADDR_W-1:0];
        data_q <= DataIn;
      end
      if (commit && rw_q == RW_READ) begin
        dout_q <= ok ? rdata : 32'h0;
      end
    end
  end

  // RAM write port: commits an aligned write on the edge entering DONE.
  always_ff @(posedge Clk) begin
    // NOTE: the storage array has no reset; contents survive Reset and this
    // keeps the array mappable onto plain RAM.
    if (commit && rw_q == RW_WRITE && ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr_q + ADDR_W'(i)] <= wbytes[i];
      end
    end
  end

  assign MOC       = (state_q == ST_DONE);
  assign Align_Err = (state_q == ST_DONE) && !ok;
  assign DataOut   = dout_q;

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Scoreboard bench for sparc_mem_responder (ADDR_W=9, WAIT_STATES=2).
module tb_sparc_mem_responder;
  import sparc_mem_pkg::*;

  localparam int ADDR_W      = 9;
  localparam int WAIT_STATES = 2;

  logic        Clk;
  logic        Reset;
  logic        MOV;
  logic        RW;
  logic [1:0]  Type;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Align_Err;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [15:0] id;
  } exp_t;

  exp_t        sb_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] last_rd = 32'h0;
  int          op_id = 0;
  logic        moc_prev = 1'b0;

  sparc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MOV       (MOV),
    .RW        (RW),
    .Type      (Type),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .MOC       (MOC),
    .Align_Err (Align_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  // Monitor: on every rising MOC, pop the expected response and compare.
  always @(negedge Clk) begin
    if (MOC && !moc_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("op%0d_dataout", e.id), DataOut, e.data);
        check($sformatf("op%0d_align_err", e.id), {31'h0, Align_Err}, {31'h0, e.err});
      end
    end
    moc_prev = MOC;
  end

  task automatic push_exp(input logic rw, input logic exp_err, input logic [31:0] exp_rd);
    exp_t e;
    if (rw == RW_READ) last_rd = exp_err ? 32'h0 : exp_rd;
    e.data = last_rd;
    e.err  = exp_err;
    e.id   = 16'(op_id);
    op_id++;
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input logic rw, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] data);
    MOV = 1'b1; RW = rw; Type = typ; Address = addr; DataIn = data;
  endtask

  // Waits (bounded) for MOC, returning the number of falling edges seen.
  task automatic wait_moc(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!MOC && n < 20);
  endtask

  // Full four-phase transaction with latency and release checks.
  task automatic do_op(input logic rw, input logic [1:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, input logic exp_err, input logic [31:0] exp_rd);
    int n;
    push_exp(rw, exp_err, exp_rd);
    @(negedge Clk);
    drive_req(rw, typ, addr, data);
    wait_moc(n);
    check("latency", 32'(n), 32'(WAIT_STATES + 2));
    MOV = 1'b0; DataIn = $urandom; Address = $urandom; RW = 1'($urandom);
    @(negedge Clk);
    check("moc_release", {31'h0, MOC}, 32'h0);
    check("align_release", {31'h0, Align_Err}, 32'h0);
  endtask

  initial begin
    int n;
    int hi;
    Reset = 1'b1; MOV = 1'b0; RW = RW_READ; Type = TYPE_BYTE; Address = '0; DataIn = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_moc", {31'h0, MOC}, 32'h0);
    check("rst_align", {31'h0, Align_Err}, 32'h0);
    check("rst_dataout", DataOut, 32'h0);
    Reset = 1'b0;

    // Word write / readback, byte extraction
    do_op(RW_WRITE, TYPE_WORD, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    do_op(RW_READ,  TYPE_WORD, 32'h010, 32'h0,       1'b0, 32'hDEADBEEF);
    do_op(RW_READ,  TYPE_BYTE, 32'h011, 32'h0,       1'b0, 32'h000000AD);

    // Halfword lanes
    do_op(RW_WRITE, TYPE_HALF, 32'h020, 32'hFFFF0000, 1'b0, 32'h0);
    do_op(RW_WRITE, TYPE_HALF, 32'h022, 32'h1234ABCD, 1'b0, 32'h0);
    do_op(RW_READ,  TYPE_WORD, 32'h020, 32'h0,        1'b0, 32'h0000ABCD);
    do_op(RW_READ,  TYPE_BYTE, 32'h023, 32'h0,        1'b0, 32'h000000CD);

    // Misalignment and reserved type
    do_op(RW_WRITE, TYPE_WORD, 32'h013, 32'h11223344, 1'b1, 32'h0);
    do_op(RW_WRITE, TYPE_RSVD, 32'h010, 32'h99999999, 1'b1, 32'h0);
    do_op(RW_READ,  TYPE_WORD, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF);
    do_op(RW_READ,  TYPE_RSVD, 32'h010, 32'h0,        1'b1, 32'h0);
    do_op(RW_READ,  TYPE_WORD, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF);
    do_op(RW_READ,  TYPE_HALF, 32'h011, 32'h0,        1'b1, 32'h0);
    do_op(RW_WRITE, TYPE_BYTE, 32'h030, 32'h000000A5, 1'b0, 32'h0);

    // Wrap and alias
    do_op(RW_WRITE, TYPE_BYTE, 32'h200, 32'hFFFFFF5A, 1'b0, 32'h0);
    do_op(RW_READ,  TYPE_BYTE, 32'h000, 32'h0,        1'b0, 32'h0000005A);
    do_op(RW_READ,  TYPE_BYTE, 32'hFFFF_FC00, 32'h0,  1'b0, 32'h0000005A);
    do_op(RW_WRITE, TYPE_HALF, 32'h1FE, 32'hFFFFBEEF, 1'b0, 32'h0);
    do_op(RW_READ,  TYPE_HALF, 32'h1FE, 32'h0,        1'b0, 32'h0000BEEF);
    do_op(RW_READ,  TYPE_BYTE, 32'h1FF, 32'h0,        1'b0, 32'h000000EF);

    // MOV dropped during BUSY: still completes, single-cycle MOC
    push_exp(RW_READ, 1'b0, 32'h000000DE);
    @(negedge Clk);
    drive_req(RW_READ, TYPE_BYTE, 32'h010, 32'h0);
    @(negedge Clk);
    MOV = 1'b0;
    wait_moc(n);
    check("drop_latency", 32'(n), 32'(WAIT_STATES + 1));
    hi = 0;
    while (MOC && hi < 10) begin
      hi++;
      @(negedge Clk);
    end
    check("drop_pulse_width", 32'(hi), 32'd1);

    // Reset while a write is in BUSY: write discarded
    @(negedge Clk);
    drive_req(RW_WRITE, TYPE_BYTE, 32'h010, 32'h00000077);
    @(negedge Clk);
    Reset = 1'b1; MOV = 1'b0;
    @(negedge Clk);
    check("busy_rst_moc", {31'h0, MOC}, 32'h0);
    check("busy_rst_align", {31'h0, Align_Err}, 32'h0);
    check("busy_rst_dataout", DataOut, 32'h0);
    Reset = 1'b0;
    last_rd = 32'h0;
    do_op(RW_READ, TYPE_BYTE, 32'h010, 32'h0, 1'b0, 32'h000000DE);

    // Reset while in DONE of a write: write already committed
    push_exp(RW_WRITE, 1'b0, 32'h0);
    @(negedge Clk);
    drive_req(RW_WRITE, TYPE_BYTE, 32'h040, 32'h00000044);
    wait_moc(n);
    check("done_rst_latency", 32'(n), 32'(WAIT_STATES + 2));
    Reset = 1'b1; MOV = 1'b0;
    @(negedge Clk);
    check("done_rst_moc", {31'h0, MOC}, 32'h0);
    check("done_rst_dataout", DataOut, 32'h0);
    Reset = 1'b0;
    last_rd = 32'h0;
    do_op(RW_READ, TYPE_BYTE, 32'h040, 32'h0, 1'b0, 32'h00000044);

    // MOV held after DONE: no re-latch, no second access
    push_exp(RW_WRITE, 1'b0, 32'h0);
    @(negedge Clk);
    drive_req(RW_WRITE, TYPE_BYTE, 32'h050, 32'h00000011);
    wait_moc(n);
    check("hold_latency", 32'(n), 32'(WAIT_STATES + 2));
    DataIn = 32'h00000022;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("hold_moc", {31'h0, MOC}, 32'h1);
    end
    MOV = 1'b0;
    @(negedge Clk);
    check("hold_release", {31'h0, MOC}, 32'h0);
    do_op(RW_READ, TYPE_BYTE, 32'h050, 32'h0, 1'b0, 32'h00000011);

    // MOV held through reset: accepted on first edge after Reset drops
    @(negedge Clk);
    Reset = 1'b1;
    drive_req(RW_READ, TYPE_BYTE, 32'h023, 32'h0);
    repeat (2) @(negedge Clk);
    check("rst_hold_moc", {31'h0, MOC}, 32'h0);
    last_rd = 32'h0;
    push_exp(RW_READ, 1'b0, 32'h000000CD);
    Reset = 1'b0;
    wait_moc(n);
    check("rst_hold_latency", 32'(n), 32'(WAIT_STATES + 2));
    MOV = 1'b0;
    @(negedge Clk);
    check("rst_hold_release", {31'h0, MOC}, 32'h0);

    repeat (3) @(negedge Clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
